// File: rtl/key_debounce_if.sv
// Signal bundle between a raw push-button and the logic that consumes its
// debounced level and strobes. The debouncer sits on the slave side.
interface key_debounce_if;
    logic key_in;       // raw asynchronous button pin
    logic repeat_en;    // 1 = auto-repeat enabled
    logic pressed;      // debounced level, 1 = pressed
    logic key_out;      // debounced level in the raw pin's polarity
    logic press_stb;    // one-cycle strobe on an accepted press
    logic release_stb;  // one-cycle strobe on an accepted release
    logic rpt_stb;      // one-cycle auto-repeat strobe

    modport master (
        output key_in,
        output repeat_en,
        input  pressed,
        input  key_out,
        input  press_stb,
        input  release_stb,
        input  rpt_stb
    );

    modport slave (
        input  key_in,
        input  repeat_en,
        output pressed,
        output key_out,
        output press_stb,
        output release_stb,
        output rpt_stb
    );
endinterface

// File: rtl/key_debounce.sv
// Single-key debouncer with auto-repeat. The raw pin is synchronised,
// normalised to 1 = pressed, and qualified by a stability counter before a
// level change is accepted. While held, an optional repeat strobe fires after
// a hold delay and then periodically. All outputs come straight from flops.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int CNT_W           = 25
) (
    input  logic         clk,
    input  logic         rst,
    key_debounce_if.slave bus
);

    // Raw pin level that means "not pressed".
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_REPEAT,
        ST_RELEASE_WAIT
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pressed_q, pressed_d;
    logic             key_out_q, key_out_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_q, rpt_d;

    // Normalised synchronised level: 1 = pressed regardless of pin polarity.
    assign s = sync2_q ^ REL_LVL;

    // Two-flop synchroniser; resets to the released level so a held key
    // is re-qualified from scratch after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= REL_LVL;
            sync2_q <= REL_LVL;
        end else begin
            sync1_q <= bus.key_in;
            sync2_q <= sync1_q;
        end
    end

    // Next-state logic: debounce qualification, hold/repeat timing, strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        rpt_d     = 1'b0;

        case (state_q)
            ST_RELEASED: begin
                cnt_d = '0;
                if (s) begin
                    state_d = ST_PRESS_WAIT;
                end
            end

            ST_PRESS_WAIT: begin
                if (!s) begin
                    // Bounce: fall back silently.
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_PRESSED;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_PRESSED: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (!bus.repeat_en) begin
                    // Hold timer only runs while repeat is enabled.
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_REPEAT;
                    rpt_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_REPEAT: begin
                if (!s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (!bus.repeat_en) begin
                    // Disabling repeat restarts the full hold delay later.
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == RPT_LAST) begin
                    rpt_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_RELEASE_WAIT: begin
                if (s) begin
                    // Release bounce: key still down, restart hold timing.
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_RELEASED;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d   = ST_RELEASED;
                cnt_d     = '0;
                pressed_d = 1'b0;
            end
        endcase

        key_out_d = pressed_d ^ REL_LVL;
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            key_out_q <= REL_LVL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
            rpt_q     <= rpt_d;
        end
    end

    assign bus.pressed     = pressed_q;
    assign bus.key_out     = key_out_q;
    assign bus.press_stb   = press_q;
    assign bus.release_stb = release_q;
    assign bus.rpt_stb     = rpt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with short timing constants. Expected strobes
// (kind + cycle) are queued as stimulus is driven; a negedge monitor pops
// and compares each strobe the DUT produces.
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int RPT  = 3;
    localparam int LAT  = DEB + 2;  // edge k samples pin -> visible after edge k+LAT

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_RPT   = 2;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (RPT),
        .ACTIVE_LOW     (1),
        .CNT_W          (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor / scoreboard consumer.
    int   mon_n;
    int   mon_kind;
    exp_t mon_e;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            mon_e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL missed_strobe: kind=%0d required at cycle %0d, not observed (now %0d)",
                     mon_e.kind, mon_e.at, cyc);
        end
        mon_n = int'(kif.press_stb) + int'(kif.release_stb) + int'(kif.rpt_stb);
        mon_kind = kif.press_stb ? K_PRESS : (kif.release_stb ? K_REL : K_RPT);
        if (mon_n > 1) begin
            total++;
            bad++;
            $display("FAIL strobe_exclusive: cycle %0d press=%b release=%b rpt=%b, required at most one",
                     cyc, kif.press_stb, kif.release_stb, kif.rpt_stb);
        end else if (mon_n == 1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: kind=%0d at cycle %0d, required none", mon_kind, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.kind !== mon_kind || mon_e.at !== cyc) begin
                    bad++;
                    $display("FAIL strobe: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                             mon_kind, cyc, mon_e.kind, mon_e.at);
                end else begin
                    $display("strobe kind=%0d cycle=%0d ok", mon_kind, cyc);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        kif.key_in = 1'b1;
        kif.repeat_en = 1'b0;
        tick(3);
        total++;
        if (kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL reset_pressed: got %b required 0", kif.pressed);
        end
        total++;
        if (kif.key_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_key_out: got %b required 1", kif.key_out);
        end
        total++;
        if ({kif.press_stb, kif.release_stb, kif.rpt_stb} !== 3'b000) begin
            bad++;
            $display("FAIL reset_strobes: got %b required 000",
                     {kif.press_stb, kif.release_stb, kif.rpt_stb});
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_clean_press();
        int k;
        kif.repeat_en = 1'b0;
        k = cyc + 1;
        push_exp(K_PRESS, k + LAT);
        kif.key_in = 1'b0;
        tick(30);
        total++;
        if (kif.pressed !== 1'b1) begin
            bad++;
            $display("FAIL clean_pressed: got %b required 1", kif.pressed);
        end
        total++;
        if (kif.key_out !== 1'b0) begin
            bad++;
            $display("FAIL clean_key_out: got %b required 0", kif.key_out);
        end
        k = cyc + 1;
        push_exp(K_REL, k + LAT);
        kif.key_in = 1'b1;
        tick(10);
        total++;
        if (kif.pressed !== 1'b0 || kif.key_out !== 1'b1) begin
            bad++;
            $display("FAIL clean_release_level: got pressed=%b key_out=%b required 0/1",
                     kif.pressed, kif.key_out);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL clean_pending: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int k;
        kif.repeat_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            kif.key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        total++;
        if (kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL bounce_no_press: got pressed=%b required 0", kif.pressed);
        end
        k = cyc + 1;
        push_exp(K_PRESS, k + LAT);
        kif.key_in = 1'b0;
        tick(15);
        total++;
        if (kif.pressed !== 1'b1) begin
            bad++;
            $display("FAIL bounce_pressed: got %b required 1", kif.pressed);
        end
        k = cyc + 1;
        push_exp(K_REL, k + LAT);
        kif.key_in = 1'b1;
        tick(10);
        total++;
        if (exp_q.size() != 0 || kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL bounce_end: got pending=%0d pressed=%b required 0/0",
                     exp_q.size(), kif.pressed);
        end
    endtask

    task automatic test_glitch();
        kif.repeat_en = 1'b0;
        kif.key_in = 1'b0;
        tick(3);
        kif.key_in = 1'b1;
        tick(12);
        total++;
        if (kif.pressed !== 1'b0 || kif.key_out !== 1'b1) begin
            bad++;
            $display("FAIL glitch_level: got pressed=%b key_out=%b required 0/1",
                     kif.pressed, kif.key_out);
        end
    endtask

    task automatic test_auto_repeat();
        int p;
        int k2;
        // Continuous hold with repeat enabled, then release.
        kif.repeat_en = 1'b1;
        p  = cyc + 1 + LAT;
        k2 = p + 31;
        push_exp(K_PRESS, p);
        for (int t = p + HOLD; t <= k2 + 1; t += RPT) push_exp(K_RPT, t);
        push_exp(K_REL, k2 + LAT);
        kif.key_in = 1'b0;
        wait_until(p + 30);
        kif.key_in = 1'b1;
        tick(10);
        total++;
        if (exp_q.size() != 0 || kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL repeat_hold_end: got pending=%0d pressed=%b required 0/0",
                     exp_q.size(), kif.pressed);
        end
        // Drop repeat_en mid-repeat: strobes stop, hold delay restarts.
        tick(2);
        p = cyc + 1 + LAT;
        push_exp(K_PRESS, p);
        push_exp(K_RPT, p + 10);
        push_exp(K_RPT, p + 13);
        push_exp(K_RPT, p + 19 + HOLD);
        push_exp(K_RPT, p + 19 + HOLD + RPT);
        push_exp(K_REL, p + 31 + LAT);
        kif.key_in = 1'b0;
        wait_until(p + 14);
        kif.repeat_en = 1'b0;
        wait_until(p + 19);
        total++;
        if (kif.pressed !== 1'b1) begin
            bad++;
            $display("FAIL repeat_disabled_pressed: got %b required 1", kif.pressed);
        end
        kif.repeat_en = 1'b1;
        wait_until(p + 30);
        kif.key_in = 1'b1;
        tick(10);
        total++;
        if (exp_q.size() != 0 || kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL repeat_toggle_end: got pending=%0d pressed=%b required 0/0",
                     exp_q.size(), kif.pressed);
        end
    endtask

    task automatic test_release_bounce();
        int p;
        kif.repeat_en = 1'b1;
        p = cyc + 1 + LAT;
        // Pin goes high for 2 cycles at p+4/p+5; back to PRESSED at edge p+8.
        push_exp(K_PRESS, p);
        push_exp(K_RPT, p + 8 + HOLD);
        push_exp(K_RPT, p + 8 + HOLD + RPT);
        push_exp(K_RPT, p + 8 + HOLD + 2 * RPT);
        push_exp(K_REL, p + 23 + LAT);
        kif.key_in = 1'b0;
        wait_until(p + 3);
        kif.key_in = 1'b1;
        tick(2);
        kif.key_in = 1'b0;
        wait_until(p + 12);
        total++;
        if (kif.pressed !== 1'b1 || kif.key_out !== 1'b0) begin
            bad++;
            $display("FAIL relbounce_level: got pressed=%b key_out=%b required 1/0",
                     kif.pressed, kif.key_out);
        end
        wait_until(p + 22);
        kif.key_in = 1'b1;
        tick(10);
        total++;
        if (exp_q.size() != 0 || kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL relbounce_end: got pending=%0d pressed=%b required 0/0",
                     exp_q.size(), kif.pressed);
        end
    endtask

    task automatic test_reset_mid_press();
        int p;
        int k;
        kif.repeat_en = 1'b0;
        p = cyc + 1 + LAT;
        push_exp(K_PRESS, p);
        kif.key_in = 1'b0;
        wait_until(p + 3);
        rst = 1'b1;
        tick(1);
        total++;
        if (kif.pressed !== 1'b0 || kif.key_out !== 1'b1) begin
            bad++;
            $display("FAIL midreset_level: got pressed=%b key_out=%b required 0/1",
                     kif.pressed, kif.key_out);
        end
        rst = 1'b0;
        k = cyc + 1;
        push_exp(K_PRESS, k + LAT);
        tick(15);
        total++;
        if (kif.pressed !== 1'b1) begin
            bad++;
            $display("FAIL midreset_requalify: got pressed=%b required 1", kif.pressed);
        end
        k = cyc + 1;
        push_exp(K_REL, k + LAT);
        kif.key_in = 1'b1;
        tick(10);
        total++;
        if (exp_q.size() != 0 || kif.pressed !== 1'b0) begin
            bad++;
            $display("FAIL midreset_end: got pending=%0d pressed=%b required 0/0",
                     exp_q.size(), kif.pressed);
        end
    endtask

    initial begin
        kif.key_in = 1'b1;
        kif.repeat_en = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_release_bounce();
        test_reset_mid_press();
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
